// File: rtl/display_pingpong_buffer.sv
// Two-bank ping-pong buffer: packed words fill one bank while the other is unpacked into pixels.
// Optional underflow reporting is enabled by defining DISPLAY_UNDERFLOW_EN.
module display_pingpong_buffer #(
    parameter int WORD_W = 32,
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 10000,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] frame_words,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              buf0_empty,
    output logic              buf1_empty,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              underflow,
    output logic [15:0]       underflow_cnt
);

    localparam int PPW    = WORD_W / PIX_W;
    localparam int PIDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
    localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(PPW - 1);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_OUT} rd_state_t;

    rd_state_t         rd_state;
    logic [WORD_W-1:0] bank0 [DEPTH];
    logic [WORD_W-1:0] bank1 [DEPTH];
    logic [WORD_W-1:0] rd_word;
    logic              wr_sel;
    logic              rd_sel;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] ridx;
    logic [PIDX_W-1:0] pidx;
    logic [1:0]        empty_q;
    logic [LEN_W-1:0]  len_q [2];
    logic [LEN_W-1:0]  len_new;
    logic [LEN_W-1:0]  wr_len;
    logic [LEN_W-1:0]  rd_len;
    logic              wr_fire;
    logic              wr_last;
    logic              rd_last;
    logic              pix_fire;
    logic              bank_done;

    always_comb begin
        len_new = {1'b0, frame_words};
        if (len_new == '0 || len_new > LEN_MAX) begin
            len_new = LEN_MAX;
        end
    end

    // The first word of a fill uses the live length; later words use the one latched with it.
    assign wr_len    = (widx == '0) ? len_new : len_q[wr_sel];
    assign rd_len    = len_q[rd_sel];
    assign wr_last   = ({1'b0, widx} == wr_len - 1'b1);
    assign rd_last   = ({1'b0, ridx} == rd_len - 1'b1);

    assign wr_ready   = empty_q[wr_sel];
    assign buf0_empty = empty_q[0];
    assign buf1_empty = empty_q[1];
    assign wr_fire    = wr_valid && wr_ready && !flush;
    assign pix_valid  = (rd_state == R_OUT);
    assign pix_fire   = pix_valid && pix_ready;
    assign bank_done  = pix_fire && (pidx == PIDX_LAST) && rd_last;
    assign pix_data   = pix_valid ? rd_word[pidx*PIX_W +: PIX_W] : '0;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wr_sel) begin
                bank1[widx] <= wr_data;
            end else begin
                bank0[widx] <= wr_data;
            end
        end
        if (rd_state == R_FETCH) begin
            rd_word <= rd_sel ? bank1[ridx] : bank0[ridx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            widx     <= '0;
            ridx     <= '0;
            pidx     <= '0;
            empty_q  <= '1;
            len_q[0] <= '0;
            len_q[1] <= '0;
            rd_state <= R_IDLE;
        end else if (flush) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            widx     <= '0;
            ridx     <= '0;
            pidx     <= '0;
            empty_q  <= '1;
            rd_state <= R_IDLE;
        end else begin
            // Writer and reader never own the same bank, so their flag updates cannot collide.
            if (wr_fire) begin
                if (widx == '0) begin
                    len_q[wr_sel] <= len_new;
                end
                if (wr_last) begin
                    empty_q[wr_sel] <= 1'b0;
                    widx            <= '0;
                    wr_sel          <= ~wr_sel;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
            case (rd_state)
                R_IDLE: begin
                    if (!empty_q[rd_sel]) begin
                        rd_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    pidx     <= '0;
                    rd_state <= R_OUT;
                end
                R_OUT: begin
                    if (pix_ready) begin
                        if (pidx != PIDX_LAST) begin
                            pidx <= pidx + 1'b1;
                        end else begin
                            pidx <= '0;
                            if (bank_done) begin
                                empty_q[rd_sel] <= 1'b1;
                                ridx            <= '0;
                                rd_sel          <= ~rd_sel;
                                rd_state        <= R_IDLE;
                            end else begin
                                ridx     <= ridx + 1'b1;
                                rd_state <= R_FETCH;
                            end
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

`ifdef DISPLAY_UNDERFLOW_EN
    logic        drained;
    logic        uf_flag;
    logic [15:0] uf_cnt;
    logic        uf_event;

    // Starving is only meaningful once at least one bank has been shown since reset/flush.
    assign uf_event = pix_ready && !pix_valid && (rd_state == R_IDLE) && drained;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drained <= 1'b0;
            uf_flag <= 1'b0;
            uf_cnt  <= '0;
        end else begin
            if (flush) begin
                drained <= 1'b0;
            end else if (bank_done) begin
                drained <= 1'b1;
            end
            if (uf_event) begin
                uf_flag <= 1'b1;
                if (uf_cnt != '1) begin
                    uf_cnt <= uf_cnt + 1'b1;
                end
            end
        end
    end

    assign underflow     = uf_flag;
    assign underflow_cnt = uf_cnt;
`else
    assign underflow     = 1'b0;
    assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_display_pingpong_buffer.sv
// Directed bench for display_pingpong_buffer: a per-cycle vector table plus scoreboarded sequences.
// Underflow expectations follow DISPLAY_UNDERFLOW_EN.
module tb_display_pingpong_buffer;

    localparam int WORD_W = 32;
    localparam int PIX_W  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] frame_words = 5'd4;
    logic              wr_valid = 1'b0;
    logic [WORD_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              buf0_empty;
    logic              buf1_empty;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic [PIX_W-1:0]  pix_data;
    logic              underflow;
    logic [15:0]       underflow_cnt;

    display_pingpong_buffer #(
        .WORD_W(WORD_W),
        .PIX_W (PIX_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .frame_words  (frame_words),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .buf0_empty   (buf0_empty),
        .buf1_empty   (buf1_empty),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .underflow    (underflow),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        pr;
        logic        e_wrr;
        logic        e_b0;
        logic        e_b1;
        logic        e_pv;
        logic [7:0]  e_pd;
    } vec_t;

    vec_t        tbl [31];
    logic [31:0] twords [4];
    logic [7:0]  expq [$];
    int          nvec = 0;
    int          nmis = 0;
    int          wsent = 0;
    int          npix = 0;
    int          gword = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic pr,
                                input logic wrr, input logic b0, input logic b1,
                                input logic pv, input logic [7:0] pd);
        vec_t v;
        v.wv = wv; v.wd = wd; v.pr = pr;
        v.e_wrr = wrr; v.e_b0 = b0; v.e_b1 = b1; v.e_pv = pv; v.e_pd = pd;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input int g);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[8*j +: 8] = 8'((g * 4 + j) & 255);
        end
        return w;
    endfunction

    task automatic check_flags(input string name, input logic b0, input logic b1,
                               input logic wrr, input logic pv);
        check({name, "_b0"}, 32'(buf0_empty), 32'(b0));
        check({name, "_b1"}, 32'(buf1_empty), 32'(b1));
        check({name, "_wrr"}, 32'(wr_ready), 32'(wrr));
        check({name, "_pv"}, 32'(pix_valid), 32'(pv));
    endtask

    // Streams words in and pixels out cycle by cycle, checking pixels against the write-order queue.
    task automatic run(input int wtarget, input logic pr, input int ptarget,
                       input int budget, input string name);
        int   cyc = 0;
        logic done;
        while ((wsent < wtarget || (pr && npix < ptarget)) && cyc < budget) begin
            @(negedge clk);
            wr_valid  = (wsent < wtarget);
            wr_data   = word_of(gword);
            pix_ready = pr && (npix < ptarget);
            if (wr_valid && wr_ready) begin
                for (int j = 0; j < 4; j++) expq.push_back(wr_data[8*j +: 8]);
                gword++;
                wsent++;
            end
            if (pix_valid && pix_ready) begin
                if (expq.size() == 0) begin
                    check({name, "_extra_pix"}, 32'(pix_data), 32'hFFFF_FFFF);
                end else begin
                    check({name, "_pix"}, 32'(pix_data), 32'(expq.pop_front()));
                end
                npix++;
            end
            cyc++;
        end
        @(negedge clk);
        wr_valid  = 1'b0;
        pix_ready = 1'b0;
        done = (wsent >= wtarget) && (!pr || npix >= ptarget);
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic flush_pulse(input string name);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expq.delete();
        check_flags(name, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        twords[0] = 32'h0302_0100;
        twords[1] = 32'h0706_0504;
        twords[2] = 32'h0B0A_0908;
        twords[3] = 32'h0F0E_0D0C;
        for (int i = 0; i < 4; i++) tbl[i] = mk(1'b1, twords[i], 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tbl[4] = mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tbl[5] = tbl[4];
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                tbl[6 + 5*k + j] = mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'(4*k + j));
            end
            if (k < 3) tbl[10 + 5*k] = mk(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        for (int i = 25; i < 30; i++) tbl[i] = mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tbl[30] = mk(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // Reset, then idle with the display asking for pixels.
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        pix_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_flags($sformatf("idle%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        check("idle_uf", 32'(underflow), 32'd0);
        check("idle_ufcnt", 32'(underflow_cnt), 32'd0);

        // Four-word fill and readout, then five starved cycles.
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_wrr", i), 32'(wr_ready), 32'(tbl[i].e_wrr));
            check($sformatf("tbl%0d_b0", i), 32'(buf0_empty), 32'(tbl[i].e_b0));
            check($sformatf("tbl%0d_b1", i), 32'(buf1_empty), 32'(tbl[i].e_b1));
            check($sformatf("tbl%0d_pv", i), 32'(pix_valid), 32'(tbl[i].e_pv));
            if (tbl[i].e_pv) check($sformatf("tbl%0d_pd", i), 32'(pix_data), 32'(tbl[i].e_pd));
            wr_valid  = tbl[i].wv;
            wr_data   = tbl[i].wd;
            pix_ready = tbl[i].pr;
        end
        @(negedge clk);
        wr_valid = 1'b0;
`ifdef DISPLAY_UNDERFLOW_EN
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_cnt", 32'(underflow_cnt), 32'd5);
`else
        check("uf_flag_off", 32'(underflow), 32'd0);
        check("uf_cnt_off", 32'(underflow_cnt), 32'd0);
`endif

        // Both banks full with the display stalled, then drain and refill bank 0.
        frame_words = 5'd4;
        flush_pulse("flushB");
        run(wsent + 8, 1'b0, npix, 40, "fillB");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = word_of(gword);
            check($sformatf("fullB%0d_wrr", i), 32'(wr_ready), 32'd0);
        end
        check_flags("fullB", 1'b0, 1'b0, 1'b0, 1'b1);
        check("fullB_pd", 32'(pix_data), 32'(expq[0]));
        run(wsent + 4, 1'b1, npix + 48, 400, "drainB");
        check("drainB_q", 32'(expq.size()), 32'd0);
        check_flags("drainB_end", 1'b1, 1'b1, 1'b1, 1'b0);

        // frame_words=0 means a full DEPTH-word fill.
        flush_pulse("flushC");
        frame_words = 5'd0;
        run(wsent + 15, 1'b0, npix, 40, "fill15");
        check("fill15_b0", 32'(buf0_empty), 32'd1);
        run(wsent + 1, 1'b0, npix, 5, "fill16");
        check("fill16_b0", 32'(buf0_empty), 32'd0);
        run(wsent, 1'b1, npix + 64, 300, "drain64");
        check("drain64_q", 32'(expq.size()), 32'd0);
        check("drain64_b0", 32'(buf0_empty), 32'd1);

        // Flush while bank 1 is being shown and bank 0 is refilled.
        flush_pulse("flushD0");
        frame_words = 5'd4;
        run(wsent + 8, 1'b0, npix, 40, "fillD");
        run(wsent + 4, 1'b1, npix + 18, 200, "partD");
        check_flags("preflushD", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        flush     = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = word_of(gword);
        pix_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        wr_valid  = 1'b0;
        pix_ready = 1'b0;
        expq.delete();
        check_flags("flushD", 1'b1, 1'b1, 1'b1, 1'b0);
        run(wsent + 4, 1'b0, npix, 10, "postD_fill");
        check("postD_b0", 32'(buf0_empty), 32'd0);
        check("postD_b1", 32'(buf1_empty), 32'd1);
        run(wsent, 1'b1, npix + 16, 100, "postD_drain");

        // Asynchronous reset in the middle of a fill.
        run(wsent + 2, 1'b0, npix, 10, "prefillE");
        #3;
        reset = 1'b0;
        #1;
        check_flags("resetE", 1'b1, 1'b1, 1'b1, 1'b0);
        check("resetE_uf", 32'(underflow), 32'd0);
        check("resetE_ufcnt", 32'(underflow_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        expq.delete();
        run(wsent + 4, 1'b0, npix, 10, "postE_fill");
        check("postE_b0", 32'(buf0_empty), 32'd0);
        check("postE_b1", 32'(buf1_empty), 32'd1);
        run(wsent, 1'b1, npix + 16, 100, "postE_drain");
        check("postE_q", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/display_pingpong_buffer.md
Name: display_pingpong_buffer

Overview:
Parametrised two-bank (ping-pong) buffer between the image loader and the display pixel path. Accepts packed WORD_W-bit words into one bank while the other bank is unpacked into PIX_W-bit pixels on a valid/ready stream. Generalises the fixed 32-bit, Buf0/Buf1 pair with a programmable fill length, variable pixel width, flush and underflow reporting.

Parameters:
WORD_W, 32, write word width; must be an integer multiple of PIX_W
PIX_W, 8, output pixel width
DEPTH, 10000, words per bank
ADDR_W, 14, word address width; 2^ADDR_W >= DEPTH

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous; empties both banks, returns both FSMs to idle
frame_words  in  ADDR_W  words per bank fill; sampled at the first word of each bank
wr_valid  in  1  write word present
wr_data  in  WORD_W  packed pixels, pixel 0 in LSBs
wr_ready  out  1  buffer accepts a word this cycle
buf0_empty  out  1  bank 0 holds no complete fill
buf1_empty  out  1  bank 1 holds no complete fill
pix_valid  out  1  pix_data valid
pix_ready  in  1  display path consumes the pixel
pix_data  out  PIX_W  current pixel
underflow  out  1  sticky underflow flag (optional feature)
underflow_cnt  out  16  underflow event count (optional feature)

Behaviour:
- Reset (reset=0): wr_sel=0, rd_sel=0, word/pixel indices 0, buf0_empty=buf1_empty=1, wr_ready=1, pix_valid=0, pix_data=0, underflow=0, underflow_cnt=0. Reset mid-fill or mid-readout discards all buffered data.
- Fill length L = frame_words, except frame_words=0 or >DEPTH gives L=DEPTH. L is latched when the word index is 0 and the first word is accepted.
- Write: wr_ready = empty flag of bank wr_sel. A word is accepted when wr_valid && wr_ready and is stored at bank[wr_sel][widx]; widx increments. On acceptance of word L-1: that bank's empty flag clears, widx returns to 0, wr_sel toggles, all in the same edge.
- Read FSM states are R_IDLE, R_FETCH and R_OUT.
  - R_IDLE: when bank rd_sel is not empty, go to R_FETCH.
  - R_FETCH: synchronous memory read of bank[rd_sel][ridx]. Lasts 1 cycle, pix_valid=0. Next state is R_OUT with word register loaded and pixel index p=0.
  - R_OUT: pix_valid=1, pix_data=word[p*PIX_W +: PIX_W]. On pix_ready, p increments.
  - After the last pixel (p=WORD_W/PIX_W-1) is consumed: if ridx<L_rd-1, ridx increments and the FSM goes to R_FETCH. Otherwise that bank's empty flag sets, ridx=0, rd_sel toggles, and the FSM goes to R_IDLE.
  - L_rd is the L latched for that bank. A 1-cycle bubble per word is permitted.
- Latency: the first pixel is valid 2 cycles after a bank's empty flag clears (IDLE→FETCH→OUT).
- Simultaneous events:
  - Writer completes one bank while the reader frees the other in the same cycle: both flags update.
  - Writer waits only on its own bank's flag. If it waits on a bank freed this cycle, wr_ready rises the next cycle.
- flush: all indices 0, both empty flags set, wr_sel=rd_sel=0, read FSM to R_IDLE, pix_valid=0. flush takes priority over a simultaneous write or read. underflow state is kept.
- Empty/full: both banks full gives wr_ready=0. Both empty with R_IDLE gives pix_valid=0 indefinitely.

Optional Feature:
Macro DISPLAY_UNDERFLOW_EN.
- Defined: an underflow event is a cycle with pix_ready=1, pix_valid=0, and the read FSM in R_IDLE while a prior bank has been read out since the last reset/flush.
  - underflow is set and sticky until reset.
  - underflow_cnt increments and saturates at 16'hFFFF.
- Not defined: underflow and underflow_cnt are tied to 0 and no counter logic is synthesised.

Test Plan:
All cases use WORD_W=32, PIX_W=8, DEPTH=16, frame_words=4.
- Reset then idle: buf0_empty=buf1_empty=1, wr_ready=1, pix_valid=0 for 20 cycles.
- Write 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with pix_ready=1: buf0_empty falls after the 4th word. pix_data sequence is 0x00..0x0F with a 1-cycle gap between words. buf0_empty rises after 0x0F.
- Write 12 words continuously, pix_ready=0: bank 0 and bank 1 fill, wr_ready=0 after word 8. Raise pix_ready: bank 0 drains, wr_ready returns, and word 9 goes into bank 0.
- frame_words=0 with 16 words written: the bank completes only after the 16th word, giving 64 pixels out.
- Assert flush during bank-1 readout with bank 0 full: next cycle both empty=1, pix_valid=0, and wr_sel=rd_sel=0. Reset asserted mid-fill gives the same result.
- With DISPLAY_UNDERFLOW_EN: after one bank drains, hold pix_ready=1 for 5 idle cycles: underflow=1 and underflow_cnt=5. Without the macro, both stay 0.
